// File: rtl/spi_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_ctrl_pkg
// Shared definitions for the SPI register controller slice:
//   - state_t       : controller FSM state encoding
//   - CMD_RW_BIT    : command byte bit selecting read (1) or write (0)
//   - CMD_ADDR_MSB  : top bit of the start-address field in the command byte
//   - DUMMY_DEFAULT : byte transmitted when no read data is pending
// -----------------------------------------------------------------------------
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CMD  = 2'b01,
    RD   = 2'b10,
    WR   = 2'b11
  } state_t;

  localparam int         CMD_RW_BIT    = 7;
  localparam int         CMD_ADDR_MSB  = 6;
  localparam logic [7:0] DUMMY_DEFAULT = 8'h00;

endpackage

// File: rtl/spi_reg_file.sv
// -----------------------------------------------------------------------------
// spi_reg_file
// NREG x 8-bit register file with one synchronous write port, one
// combinational read port and a flat view of every register.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset, clears every register
//   we        in   write enable
//   addr      in   write address (AW bits, caller guarantees it is in range)
//   data      in   write data
//   rd_addr   in   read address, full 7-bit pointer
//   rd_data   out  reg[rd_addr], or 8'h00 when rd_addr >= NREG
//   regs_flat out  register i at [8i+7:8i]
// -----------------------------------------------------------------------------
module spi_reg_file #(
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [7:0]        data,
  input  logic [6:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic [8*NREG-1:0] regs_flat
);

  logic [7:0] mem [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= 8'h00;
    end else if (we) begin
      mem[addr] <= data;
    end
  end

  // The pointer is 7 bits wide regardless of NREG, so addresses past the
  // implemented registers must read as zero instead of aliasing.
  always_comb begin
    rd_data = 8'h00;
    if (int'(rd_addr) < NREG) rd_data = mem[rd_addr[AW-1:0]];
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = mem[g];
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
// Byte-level command controller behind the SPI slave byte engine. A frame is
// one command byte (bit7 = read, bits[6:0] = start address) followed by data
// bytes that are written to, or read from, the internal register file.
//
// Configuration macro: SPI_REG_CTRL_AUTOINC_EN
//   defined   : the pointer advances after every data byte (burst access)
//   undefined : the pointer stays on the command address for the whole frame
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   ncs          in   SPI chip select, active-low, raw from the pad
//   rhr          in   received byte from the slave
//   rxrdy_tick   in   one-cycle end-of-byte pulse from the slave
//   thr          out  next byte to transmit
//   regs_flat    out  register file contents, reg i at [8i+7:8i]
//   wr_tick      out  one-cycle pulse per committed write
//   wr_addr      out  address of the committed write
//   wr_data      out  data of the committed write
//   frame_active out  high while in CMD/RD/WR
// -----------------------------------------------------------------------------
module spi_reg_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int         NREG  = 16,
  parameter logic [7:0] DUMMY = DUMMY_DEFAULT,
  localparam int        AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ncs,
  input  logic [7:0]        rhr,
  input  logic              rxrdy_tick,
  output logic [7:0]        thr,
  output logic [8*NREG-1:0] regs_flat,
  output logic              wr_tick,
  output logic [AW-1:0]     wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_active
);

`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam logic [6:0] PTR_STEP = 7'd1;
`else
  localparam logic [6:0] PTR_STEP = 7'd0;
`endif

  state_t     state;
  logic [6:0] ptr;
  logic       byte_v;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       ptr_in_range;
  logic       reg_we;

  // The slave only updates rhr on the clock after rxrdy_tick, so decoding is
  // done one cycle later when rhr is guaranteed to hold the new byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) byte_v <= 1'b0;
    else       byte_v <= rxrdy_tick;
  end

  // During the command byte the address comes straight from rhr so the first
  // read data is loaded on the same edge that latches the pointer.
  assign rd_addr      = (state == CMD) ? rhr[CMD_ADDR_MSB:0] : ptr;
  assign ptr_in_range = (int'(ptr) < NREG);
  assign reg_we       = byte_v && (state == WR) && ptr_in_range;

  spi_reg_file #(
    .NREG (NREG),
    .AW   (AW)
  ) u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .we        (reg_we),
    .addr      (ptr[AW-1:0]),
    .data      (rhr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .regs_flat (regs_flat)
  );

  // Byte handling comes first and chip-select handling last, so a byte that
  // lands in the same cycle as ncs rising still commits, after which the
  // frame is closed and thr falls back to DUMMY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= 7'd0;
      thr          <= DUMMY;
      wr_tick      <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 8'h00;
      frame_active <= 1'b0;
    end else begin
      wr_tick <= 1'b0;

      if (byte_v) begin
        unique case (state)
          CMD: begin
            if (rhr[CMD_RW_BIT]) begin
              state <= RD;
              thr   <= rd_data;
              ptr   <= rhr[CMD_ADDR_MSB:0] + PTR_STEP;
            end else begin
              state <= WR;
              ptr   <= rhr[CMD_ADDR_MSB:0];
            end
          end
          RD: begin
            thr <= rd_data;
            ptr <= ptr + PTR_STEP;
          end
          WR: begin
            if (ptr_in_range) begin
              wr_tick <= 1'b1;
              wr_addr <= ptr[AW-1:0];
              wr_data <= rhr;
            end
            ptr <= ptr + PTR_STEP;
          end
          default: ;
        endcase
      end

      if (ncs) begin
        state        <= IDLE;
        thr          <= DUMMY;
        frame_active <= 1'b0;
      end else if (state == IDLE) begin
        state        <= CMD;
        thr          <= DUMMY;
        frame_active <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_ctrl
// Directed bench for spi_reg_ctrl (NREG = 16). The slave byte engine is
// modelled at byte level: each byte occupies 16 SPCK phases of 10 clk, then
// rxrdy_tick pulses and rhr changes on the following clock. The MISO byte of
// each transfer is the thr value present when that byte starts.
// Expected values follow SPI_REG_CTRL_AUTOINC_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_spi_reg_ctrl;

  localparam int NREG      = 16;
  localparam int AW        = $clog2(NREG);
  localparam int BYTE_CLKS = 160;

`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              ncs;
  logic [7:0]        rhr;
  logic              rxrdy_tick;
  logic [7:0]        thr;
  logic [8*NREG-1:0] regs_flat;
  logic              wr_tick;
  logic [AW-1:0]     wr_addr;
  logic [7:0]        wr_data;
  logic              frame_active;

  int errors = 0;
  int checks = 0;

  int         tick_total = 0;
  logic [7:0] addr_log [64];
  logic [7:0] data_log [64];

  spi_reg_ctrl #(.NREG(NREG)) dut (
    .clk          (clk),
    .reset        (reset),
    .ncs          (ncs),
    .rhr          (rhr),
    .rxrdy_tick   (rxrdy_tick),
    .thr          (thr),
    .regs_flat    (regs_flat),
    .wr_tick      (wr_tick),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_active (frame_active)
  );

  always #5 clk = ~clk;

  // Log every committed write so steps can check count, address and data.
  always @(negedge clk) begin
    if (wr_tick === 1'b1) begin
      if (tick_total < 64) begin
        addr_log[tick_total] = 8'(wr_addr);
        data_log[tick_total] = wr_data;
      end
      tick_total = tick_total + 1;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    checks = checks + 1;
    assert (observed === expected) else begin
      errors = errors + 1;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic start_frame;
    ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame;
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic raise_ncs,
                           output logic [7:0] miso);
    miso = thr;
    repeat (BYTE_CLKS) @(negedge clk);
    rxrdy_tick = 1'b1;
    @(negedge clk);
    rxrdy_tick = 1'b0;
    rhr        = b;
    if (raise_ncs) ncs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [7:0] reg_at(input int i);
    return regs_flat[8*i +: 8];
  endfunction

  initial begin
    logic [7:0] m0, m1, m2, m3;
    int base;

    reset      = 1'b1;
    ncs        = 1'b1;
    rhr        = 8'h00;
    rxrdy_tick = 1'b0;
    repeat (3) @(negedge clk);

    check_output("reset_thr", 128'(thr), 128'h00);
    check_output("reset_regs", 128'(regs_flat), 128'h0);
    check_output("reset_wr_tick", 128'(wr_tick), 128'h0);
    check_output("reset_wr_addr", 128'(wr_addr), 128'h0);
    check_output("reset_wr_data", 128'(wr_data), 128'h0);
    check_output("reset_frame_active", 128'(frame_active), 128'h0);

    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_output("idle_frame_active", 128'(frame_active), 128'h0);

    // Write burst 0x02, 0x11, 0x22, 0x33
    $display("[TB] write burst");
    base = tick_total;
    start_frame();
    check_output("frame_active_high", 128'(frame_active), 128'h1);
    send_byte(8'h02, 1'b0, m0);
    send_byte(8'h11, 1'b0, m0);
    send_byte(8'h22, 1'b0, m0);
    send_byte(8'h33, 1'b0, m0);
    end_frame();
    check_output("wb_tick_count", 128'(tick_total - base), 128'd3);
    check_output("wb_addr0", 128'(addr_log[base]), 128'd2);
    check_output("wb_addr1", 128'(addr_log[base+1]), AUTOINC ? 128'd3 : 128'd2);
    check_output("wb_addr2", 128'(addr_log[base+2]), AUTOINC ? 128'd4 : 128'd2);
    check_output("wb_data2", 128'(data_log[base+2]), 128'h33);
    check_output("wb_reg2", 128'(reg_at(2)), AUTOINC ? 128'h11 : 128'h33);
    check_output("wb_reg3", 128'(reg_at(3)), AUTOINC ? 128'h22 : 128'h00);
    check_output("wb_reg4", 128'(reg_at(4)), AUTOINC ? 128'h33 : 128'h00);

    // Read burst 0x82 plus three dummy bytes
    $display("[TB] read burst");
    base = tick_total;
    start_frame();
    send_byte(8'h82, 1'b0, m0);
    send_byte(8'h00, 1'b0, m1);
    send_byte(8'h00, 1'b0, m2);
    send_byte(8'h00, 1'b0, m3);
    end_frame();
    check_output("rb_miso0", 128'(m0), 128'h00);
    check_output("rb_miso1", 128'(m1), AUTOINC ? 128'h11 : 128'h33);
    check_output("rb_miso2", 128'(m2), AUTOINC ? 128'h22 : 128'h33);
    check_output("rb_miso3", 128'(m3), 128'h33);
    check_output("rb_no_tick", 128'(tick_total - base), 128'd0);
    check_output("idle_thr_dummy", 128'(thr), 128'h00);

    // Last register and the step past it
    $display("[TB] top register");
    base = tick_total;
    start_frame();
    send_byte(8'h0F, 1'b0, m0);
    send_byte(8'hAA, 1'b0, m0);
    send_byte(8'hBB, 1'b0, m0);
    end_frame();
    check_output("top_tick_count", 128'(tick_total - base), AUTOINC ? 128'd1 : 128'd2);
    check_output("top_addr0", 128'(addr_log[base]), 128'd15);
    check_output("top_reg15", 128'(reg_at(15)), AUTOINC ? 128'hAA : 128'hBB);
    start_frame();
    send_byte(8'h8F, 1'b0, m0);
    send_byte(8'h00, 1'b0, m1);
    send_byte(8'h00, 1'b0, m2);
    end_frame();
    check_output("top_miso1", 128'(m1), AUTOINC ? 128'hAA : 128'hBB);
    check_output("top_miso2", 128'(m2), AUTOINC ? 128'h00 : 128'hBB);

    // Command address beyond NREG
    $display("[TB] out of range");
    base = tick_total;
    start_frame();
    send_byte(8'h20, 1'b0, m0);
    send_byte(8'h77, 1'b0, m0);
    end_frame();
    check_output("oor_no_tick", 128'(tick_total - base), 128'd0);
    start_frame();
    send_byte(8'hA0, 1'b0, m0);
    send_byte(8'h00, 1'b0, m1);
    end_frame();
    check_output("oor_read_zero", 128'(m1), 128'h00);

    // Pointer wrap from 127 back to 0
    $display("[TB] pointer wrap");
    base = tick_total;
    start_frame();
    send_byte(8'h00, 1'b0, m0);
    send_byte(8'hC3, 1'b0, m0);
    end_frame();
    check_output("wrap_tick_count", 128'(tick_total - base), 128'd1);
    check_output("wrap_reg0", 128'(reg_at(0)), 128'hC3);
    start_frame();
    send_byte(8'hFF, 1'b0, m0);
    send_byte(8'h00, 1'b0, m1);
    send_byte(8'h00, 1'b0, m2);
    end_frame();
    check_output("wrap_miso1", 128'(m1), 128'h00);
    check_output("wrap_miso2", 128'(m2), AUTOINC ? 128'hC3 : 128'h00);

    // Abort mid data byte
    $display("[TB] abort");
    base = tick_total;
    start_frame();
    send_byte(8'h05, 1'b0, m0);
    repeat (BYTE_CLKS / 2) @(negedge clk);
    ncs = 1'b1;
    @(negedge clk);
    check_output("abort_frame_active", 128'(frame_active), 128'h0);
    check_output("abort_thr", 128'(thr), 128'h00);
    repeat (4) @(negedge clk);
    check_output("abort_reg5", 128'(reg_at(5)), 128'h00);
    check_output("abort_no_tick", 128'(tick_total - base), 128'd0);

    // Reset during the second data byte of a write burst
    $display("[TB] reset mid-frame");
    start_frame();
    send_byte(8'h06, 1'b0, m0);
    send_byte(8'h44, 1'b0, m0);
    check_output("rst_pre_reg6", 128'(reg_at(6)), 128'h44);
    repeat (BYTE_CLKS / 2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("rst_regs_zero", 128'(regs_flat), 128'h0);
    check_output("rst_thr", 128'(thr), 128'h00);
    check_output("rst_frame_active", 128'(frame_active), 128'h0);
    ncs = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    base = tick_total;
    start_frame();
    send_byte(8'h01, 1'b0, m0);
    send_byte(8'h5A, 1'b0, m0);
    end_frame();
    check_output("rst_next_reg1", 128'(reg_at(1)), 128'h5A);
    check_output("rst_next_reg0", 128'(reg_at(0)), 128'h00);
    check_output("rst_next_tick", 128'(tick_total - base), 128'd1);

    // Last data byte arriving together with ncs rising
    $display("[TB] byte with ncs rise");
    base = tick_total;
    start_frame();
    send_byte(8'h08, 1'b0, m0);
    send_byte(8'h99, 1'b1, m0);
    check_output("edge_frame_active", 128'(frame_active), 128'h0);
    check_output("edge_reg8", 128'(reg_at(8)), 128'h99);
    check_output("edge_tick_count", 128'(tick_total - base), 128'd1);
    check_output("edge_addr", 128'(addr_log[base]), 128'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
